// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-stage registers of the ARM core:
// per-stage payload widths, bubble (NOP) encodings and counter defaults.
package pipe_pkg;

   // Default performance-counter width.
   localparam int CNT_W_DEF = 16;

   // Stage payload widths.
   localparam int IF_ID_W  = 64;   // {pc, instr}
   localparam int ID_EX_W  = 128;  // {pc, decoded control, operands}
   localparam int EX_MEM_W = 96;   // {pc, result, store data}
   localparam int MEM_WB_W = 72;   // {rd, write data, flags}

   // ARM "MOV r0, r0" used as the architectural NOP.
   localparam logic [31:0] ARM_NOP = 32'hE1A0_0000;

   // Bubble payloads per stage.
   localparam logic [IF_ID_W-1:0]  IF_ID_NOP  = {32'h0, ARM_NOP};
   localparam logic [ID_EX_W-1:0]  ID_EX_NOP  = '0;
   localparam logic [EX_MEM_W-1:0] EX_MEM_NOP = '0;
   localparam logic [MEM_WB_W-1:0] MEM_WB_NOP = '0;

   // Number of held beats from the two entry valid bits.
   function automatic logic [1:0] occ_of(input logic m_valid, input logic s_valid);
      return {1'b0, m_valid} + {1'b0, s_valid};
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
   parameter int CNT_W = pipe_pkg::CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear, else increment unless already at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Count register.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register: payload with valid/ready handshake, optional
// skid entry (registered in_ready), flush-to-bubble and stall/bubble counters.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int                DATA_W    = IF_ID_W,
   parameter logic [DATA_W-1:0] RESET_VAL = '0,
   parameter int                SKID      = 1,
   parameter int                CNT_W     = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occ,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
);

   // Main entry M (drives the outputs) and skid entry S.
   logic              m_valid_q, m_valid_d;
   logic [DATA_W-1:0] m_data_q,  m_data_d;
   logic              s_valid_q, s_valid_d;
   logic [DATA_W-1:0] s_data_q,  s_data_d;

   logic in_fire;
   logic out_fire;
   logic m_free;

   // With a skid entry, in_ready depends only on state and flush, so
   // downstream out_ready never reaches upstream combinationally.
   assign in_ready = (SKID != 0) ? (~s_valid_q & ~flush)
                                 : ((~m_valid_q | out_ready) & ~flush);

   assign in_fire  = in_valid & in_ready;
   assign out_fire = m_valid_q & out_ready;
   // M may take a new beat when it is empty or its beat leaves this cycle.
   assign m_free   = ~m_valid_q | out_ready;

   // Next-state for both entries; emptied entries return to RESET_VAL.
   // NOTE: every variable gets its default first, so no path leaves one
   // unassigned and no latch is inferred.
   always_comb begin
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      s_valid_d = s_valid_q;
      s_data_d  = s_data_q;

      if (flush) begin
         m_valid_d = 1'b0;
         m_data_d  = RESET_VAL;
         s_valid_d = 1'b0;
         s_data_d  = RESET_VAL;
      end else if (SKID != 0) begin
         if (m_free) begin
            if (s_valid_q) begin
               // Older skid beat moves forward first to keep FIFO order.
               m_valid_d = 1'b1;
               m_data_d  = s_data_q;
               s_valid_d = 1'b0;
               s_data_d  = RESET_VAL;
            end else if (in_fire) begin
               m_valid_d = 1'b1;
               m_data_d  = in_data;
            end else begin
               m_valid_d = 1'b0;
               m_data_d  = RESET_VAL;
            end
         end else if (in_fire) begin
            // M is stalled: park the accepted beat in S.
            s_valid_d = 1'b1;
            s_data_d  = in_data;
         end
      end else begin
         if (in_fire) begin
            m_valid_d = 1'b1;
            m_data_d  = in_data;
         end else if (out_fire) begin
            m_valid_d = 1'b0;
            m_data_d  = RESET_VAL;
         end
      end
   end

   // Entry registers.
   // NOTE: the payload registers are reset too, because out_data must show
   // the bubble encoding immediately after reset, not an arbitrary value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid_q <= 1'b0;
         m_data_q  <= RESET_VAL;
         s_valid_q <= 1'b0;
         s_data_q  <= RESET_VAL;
      end else begin
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         s_valid_q <= s_valid_d;
         s_data_q  <= s_data_d;
      end
   end

   assign out_valid = m_valid_q;
   assign out_data  = m_data_q;
   assign occ       = occ_of(m_valid_q, s_valid_q);

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (cnt_clr),
      .inc_i (m_valid_q & ~out_ready),
      .cnt_o (stall_cnt)
   );

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_bubble_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (cnt_clr),
      .inc_i (~m_valid_q),
      .cnt_o (bubble_cnt)
   );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances (SKID=1, SKID=0, SKID=1 with
// 4-bit counters) checked every cycle against a FIFO-level reference model.
module tb_pipe_stage_reg;

   localparam int          N   = 3;
   localparam logic [31:0] NOP = 32'hE1A0_0000;

   logic clk = 1'b0;
   logic rst;

   logic        flush     [N];
   logic        in_valid  [N];
   logic        out_ready [N];
   logic        cnt_clr   [N];
   logic [31:0] in_data   [N];

   logic        ir0, ir1, ir2, ov0, ov1, ov2;
   logic [31:0] od0, od1, od2;
   logic [1:0]  oc0, oc1, oc2;
   logic [15:0] sc0, sc1, bc0, bc1;
   logic [3:0]  sc2, bc2;

   logic        in_ready_a   [N];
   logic        out_valid_a  [N];
   logic [31:0] out_data_a   [N];
   logic [1:0]  occ_a        [N];
   logic [15:0] stall_cnt_a  [N];
   logic [15:0] bubble_cnt_a [N];

   // Reference model: a 2-deep FIFO of beats plus two saturating counts.
   int          msize  [N];
   logic [31:0] mfifo  [N][2];
   int          mstall [N];
   int          mbub   [N];
   int          cmax   [N];
   bit          skid   [N];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.DATA_W(32), .RESET_VAL(NOP), .SKID(1), .CNT_W(16)) dut_skid (
      .clk(clk), .rst(rst), .flush(flush[0]), .in_valid(in_valid[0]), .in_ready(ir0),
      .in_data(in_data[0]), .out_valid(ov0), .out_ready(out_ready[0]), .out_data(od0),
      .occ(oc0), .cnt_clr(cnt_clr[0]), .stall_cnt(sc0), .bubble_cnt(bc0));

   pipe_stage_reg #(.DATA_W(32), .RESET_VAL(NOP), .SKID(0), .CNT_W(16)) dut_noskid (
      .clk(clk), .rst(rst), .flush(flush[1]), .in_valid(in_valid[1]), .in_ready(ir1),
      .in_data(in_data[1]), .out_valid(ov1), .out_ready(out_ready[1]), .out_data(od1),
      .occ(oc1), .cnt_clr(cnt_clr[1]), .stall_cnt(sc1), .bubble_cnt(bc1));

   pipe_stage_reg #(.DATA_W(32), .RESET_VAL(NOP), .SKID(1), .CNT_W(4)) dut_cnt4 (
      .clk(clk), .rst(rst), .flush(flush[2]), .in_valid(in_valid[2]), .in_ready(ir2),
      .in_data(in_data[2]), .out_valid(ov2), .out_ready(out_ready[2]), .out_data(od2),
      .occ(oc2), .cnt_clr(cnt_clr[2]), .stall_cnt(sc2), .bubble_cnt(bc2));

   always_comb begin
      in_ready_a[0] = ir0;  in_ready_a[1] = ir1;  in_ready_a[2] = ir2;
      out_valid_a[0] = ov0; out_valid_a[1] = ov1; out_valid_a[2] = ov2;
      out_data_a[0] = od0;  out_data_a[1] = od1;  out_data_a[2] = od2;
      occ_a[0] = oc0;       occ_a[1] = oc1;       occ_a[2] = oc2;
      stall_cnt_a[0] = sc0; stall_cnt_a[1] = sc1; stall_cnt_a[2] = {12'h0, sc2};
      bubble_cnt_a[0] = bc0; bubble_cnt_a[1] = bc1; bubble_cnt_a[2] = {12'h0, bc2};
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic exp_in_ready(input int d);
      if (flush[d]) return 1'b0;
      if (skid[d]) return msize[d] < 2;
      return (msize[d] == 0) || out_ready[d];
   endfunction

   task automatic set_all(input logic iv, input logic [31:0] id, input logic ordy,
                          input logic fl, input logic clr);
      for (int d = 0; d < N; d++) begin
         in_valid[d] = iv; in_data[d] = id; out_ready[d] = ordy;
         flush[d] = fl; cnt_clr[d] = clr;
      end
   endtask

   task automatic model_clear();
      for (int d = 0; d < N; d++) begin
         msize[d] = 0; mstall[d] = 0; mbub[d] = 0;
      end
   endtask

   // Called at a falling edge with inputs applied: compare every output with
   // the model, advance the model by one clock, and return at the next fall.
   task automatic cycle();
      logic er;
      int   old;
      #1;
      for (int d = 0; d < N; d++) begin
         er = exp_in_ready(d);
         check($sformatf("d%0d in_ready", d), {31'h0, in_ready_a[d]}, {31'h0, er});
         check($sformatf("d%0d out_valid", d), {31'h0, out_valid_a[d]}, (msize[d] > 0) ? 1 : 0);
         check($sformatf("d%0d out_data", d), out_data_a[d], (msize[d] > 0) ? mfifo[d][0] : NOP);
         check($sformatf("d%0d occ", d), {30'h0, occ_a[d]}, msize[d]);
         check($sformatf("d%0d stall_cnt", d), {16'h0, stall_cnt_a[d]}, mstall[d]);
         check($sformatf("d%0d bubble_cnt", d), {16'h0, bubble_cnt_a[d]}, mbub[d]);

         old = msize[d];
         if (flush[d]) begin
            msize[d] = 0;
         end else begin
            if (old > 0 && out_ready[d]) begin
               mfifo[d][0] = mfifo[d][1];
               msize[d]--;
            end
            if (in_valid[d] && er) begin
               mfifo[d][msize[d]] = in_data[d];
               msize[d]++;
            end
         end
         if (cnt_clr[d]) begin
            mstall[d] = 0;
            mbub[d]   = 0;
         end else begin
            if (old > 0 && !out_ready[d] && mstall[d] < cmax[d]) mstall[d]++;
            if (old == 0 && mbub[d] < cmax[d]) mbub[d]++;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   // Outputs while rst is asserted must already be at their reset values.
   task automatic reset_check(input string tag);
      for (int d = 0; d < N; d++) begin
         check($sformatf("%s d%0d out_valid", tag, d), {31'h0, out_valid_a[d]}, 0);
         check($sformatf("%s d%0d out_data", tag, d), out_data_a[d], NOP);
         check($sformatf("%s d%0d occ", tag, d), {30'h0, occ_a[d]}, 0);
         check($sformatf("%s d%0d stall_cnt", tag, d), {16'h0, stall_cnt_a[d]}, 0);
         check($sformatf("%s d%0d bubble_cnt", tag, d), {16'h0, bubble_cnt_a[d]}, 0);
      end
   endtask

   initial begin
      skid[0] = 1'b1; skid[1] = 1'b0; skid[2] = 1'b1;
      cmax[0] = 65535; cmax[1] = 65535; cmax[2] = 15;
      model_clear();
      set_all(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      #1;
      reset_check("por");
      @(negedge clk);
      rst = 1'b0;
      cycle();

      // Streaming 0x1..0x8 with out_ready high, then idle.
      for (int i = 1; i <= 8; i++) begin
         set_all(1'b1, i, 1'b1, 1'b0, 1'b0);
         cycle();
      end
      set_all(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      repeat (3) cycle();

      // Back-pressure: 0xA then 0xB offered while out_ready is low.
      set_all(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
      cycle();
      set_all(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
      cycle();
      set_all(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      #1;
      check("bp occ", {30'h0, oc0}, 2);
      check("bp in_ready", {31'h0, ir0}, 0);
      check("bp out_data", od0, 32'hA);
      check("noskid bp in_ready", {31'h0, ir1}, 0);
      repeat (3) cycle();
      set_all(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      repeat (3) cycle();

      // Flush with two beats held and a beat offered.
      set_all(1'b1, 32'hC1, 1'b0, 1'b0, 1'b0);
      cycle();
      set_all(1'b1, 32'hC2, 1'b0, 1'b0, 1'b0);
      cycle();
      set_all(1'b1, 32'hC3, 1'b0, 1'b1, 1'b0);
      #1;
      check("flush in_ready", {31'h0, ir0}, 0);
      cycle();
      set_all(1'b1, 32'hC3, 1'b0, 1'b0, 1'b0);
      #1;
      check("post-flush occ", {30'h0, oc0}, 0);
      check("post-flush out_data", od0, NOP);
      check("post-flush in_ready", {31'h0, ir0}, 1);
      cycle();
      set_all(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      repeat (2) cycle();

      // Simultaneous in_fire and out_fire keeps one beat held.
      set_all(1'b1, 32'h51, 1'b0, 1'b0, 1'b0);
      cycle();
      set_all(1'b1, 32'h52, 1'b1, 1'b0, 1'b0);
      cycle();
      check("noskid occ steady", {30'h0, oc1}, 1);
      check("noskid out_data", od1, 32'h52);

      // Saturation of the 4-bit counters and clear.
      set_all(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      cycle();
      set_all(1'b1, 32'h66, 1'b0, 1'b0, 1'b0);
      cycle();
      set_all(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      repeat (20) cycle();
      check("cnt4 stall sat", {28'h0, sc2}, 15);
      check("cnt4 held data", od2, 32'h66);
      set_all(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      cycle();
      check("cnt4 stall clr", {28'h0, sc2}, 0);
      set_all(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      cycle();
      check("cnt4 stall resume", {28'h0, sc2}, 1);

      // Randomised traffic, each instance driven independently.
      for (int c = 0; c < 600; c++) begin
         for (int d = 0; d < N; d++) begin
            in_valid[d]  = ($urandom % 4) != 0;
            in_data[d]   = $urandom;
            out_ready[d] = ($urandom % 3) != 0;
            flush[d]     = ($urandom % 20) == 0;
            cnt_clr[d]   = ($urandom % 40) == 0;
         end
         cycle();
      end

      // Asynchronous reset with beats held.
      set_all(1'b1, 32'h77, 1'b0, 1'b0, 1'b0);
      cycle();
      set_all(1'b1, 32'h78, 1'b0, 1'b0, 1'b0);
      cycle();
      set_all(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      #3;
      rst = 1'b1;
      #1;
      reset_check("mid");
      model_clear();
      @(negedge clk);
      rst = 1'b0;
      cycle();
      cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
